// File: rtl/rv_muldiv_seq.sv
// Iterative RV32M/RV64M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Latency: XLEN+1 cycles from the accepting edge to the done pulse, fixed for every op and operand.
// Backpressure: start is ignored while busy (no queuing); flush aborts in-flight work with no done.
//
// Ports:
//   clk, reset_n        rising-edge clock, asynchronous active-low reset
//   start, flush        request (sampled only in IDLE) / synchronous abort (wins over start)
//   funct3, a, b        op select (0 MUL .. 7 REMU), rs1 and rs2 operands
//   busy, done, result  op in flight / one-cycle completion pulse / result held until next accepted op
module rv_muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam int PW    = 2 * XLEN;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  // hi/lo: product halves for multiply, remainder/quotient for divide.
  // lo starts as multiplier (mul) or dividend (div) magnitude.
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  // opnd: multiplicand magnitude (mul) or divisor magnitude (div).
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic              sa_q, sa_d;
  logic              sb_q, sb_d;
  logic              bz_q, bz_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              done_q, done_d;

  logic              a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum, div_shift, div_trial;
  logic [PW-1:0]     prod, prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, fix_res;

  always_comb begin
    // Operand sign handling for the incoming request.
    a_signed = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) || (funct3 == 3'd6);
    b_signed = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
    a_neg    = a_signed & a[XLEN-1];
    b_neg    = b_signed & b[XLEN-1];
    a_mag    = a_neg ? (XLEN'(0) - a) : a;
    b_mag    = b_neg ? (XLEN'(0) - b) : b;

    // One multiply step: conditional add into the high half, then shift the pair right.
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    // One restoring divide step: shift in the next dividend bit and trial-subtract.
    // The XLEN+1 bit width holds both the shifted remainder and the sign of the trial.
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_trial = div_shift - {1'b0, opnd_q};

    // Sign correction and output word selection.
    prod   = {hi_q, lo_q};
    prod_s = (sa_q ^ sb_q) ? (PW'(0) - prod) : prod;
    quo_s  = (sa_q ^ sb_q) ? (XLEN'(0) - lo_q) : lo_q;
    rem_s  = sa_q ? (XLEN'(0) - hi_q) : hi_q;
    // Divide by zero leaves the dividend in the remainder naturally (every trial succeeds
    // on a zero divisor), so only the quotient needs forcing to all-ones.
    case (f3_q)
      3'd0:          fix_res = prod_s[XLEN-1:0];
      3'd1, 3'd2,
      3'd3:          fix_res = prod_s[PW-1:XLEN];
      3'd4, 3'd5:    fix_res = bz_q ? {XLEN{1'b1}} : quo_s;
      default:       fix_res = rem_s;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    bz_d     = bz_q;
    result_d = result_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          f3_d  = funct3;
          sa_d  = a_neg;
          sb_d  = b_neg;
          bz_d  = (b == '0);
          hi_d  = '0;
          if (funct3[2]) begin
            lo_d   = a_mag;
            opnd_d = b_mag;
          end else begin
            lo_d   = b_mag;
            opnd_d = a_mag;
          end
          cnt_d   = CNT_W'(XLEN);
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (f3_q[2]) begin
          if (!div_trial[XLEN]) begin
            hi_d = div_trial[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b1};
          end else begin
            hi_d = div_shift[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b0};
          end
        end else begin
          {hi_d, lo_d} = {mul_sum, lo_q[XLEN-1:1]};
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        result_d = fix_res;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything, including a start sampled in IDLE.
    if (flush) begin
      state_d  = S_IDLE;
      done_d   = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      bz_q     <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      bz_q     <= bz_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_rv_muldiv_seq.sv
// Directed bench for rv_muldiv_seq at XLEN=32: arithmetic, corner cases, handshake, abort.
module tb_rv_muldiv_seq;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int tests_run;
  int tests_failed;

  rv_muldiv_seq #(.XLEN(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .flush   (flush),
    .funct3  (funct3),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge (E0), then scramble the inputs to show only latched copies matter.
  task automatic start_op(input logic [2:0] f, input logic [31:0] av, input logic [31:0] bv);
    funct3 = f;
    a      = av;
    b      = bv;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    funct3 = 3'($urandom_range(7));
    a      = $urandom;
    b      = $urandom;
  endtask

  // Count edges after E0 until done is seen, bounded.
  task automatic wait_done(input int l0, output int lat);
    lat = l0;
    while (done !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start   = 1'b0;
    flush   = 1'b0;
    funct3  = 3'd0;
    a       = '0;
    b       = '0;
    repeat (3) tick();
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_state: busy=%b done=%b result=%h, want 0/0/00000000", busy, done, result);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_mul_timing();
    int bad;
    bad = 0;
    start_op(3'd0, 32'd7, 32'hFFFF_FFFD);
    for (int k = 0; k < 33; k++) begin
      if (busy !== 1'b1 || done !== 1'b0) bad++;
      tick();
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL mul_busy_window: %0d bad cycles, want 0", bad);
    end
    tests_run++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL mul_done_at_33: done=%b busy=%b, want 1/0", done, busy);
    end
    tests_run++;
    if (result !== 32'hFFFF_FFEB) begin
      tests_failed++;
      $display("FAIL mul_result: got %h want ffffffeb", result);
    end
    tick();
    tests_run++;
    if (done !== 1'b0 || result !== 32'hFFFF_FFEB) begin
      tests_failed++;
      $display("FAIL done_one_cycle: done=%b result=%h, want 0/ffffffeb", done, result);
    end
  endtask

  task automatic test_multiply();
    logic [2:0]  f  [7] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3};
    logic [31:0] av [7] = '{32'h1234_5678, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                            32'h0000_0002, 32'hFFFF_FFFF, 32'h0001_0000};
    logic [31:0] bv [7] = '{32'h0000_0010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0002,
                            32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0001_0000};
    logic [31:0] ex [7] = '{32'h2345_6780, 32'h4000_0000, 32'h0000_0000, 32'hFFFF_FFFF,
                            32'h0000_0001, 32'hFFFF_FFFE, 32'h0000_0001};
    int lat;
    for (int i = 0; i < 7; i++) begin
      start_op(f[i], av[i], bv[i]);
      wait_done(0, lat);
      tests_run++;
      if (result !== ex[i] || lat !== 33) begin
        tests_failed++;
        $display("FAIL mul_vec%0d f3=%0d: result=%h lat=%0d, want %h lat=33", i, f[i], result, lat, ex[i]);
      end
      tick();
    end
  endtask

  task automatic test_divide();
    logic [2:0]  f  [6] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6};
    logic [31:0] av [6] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd7, 32'd7};
    logic [31:0] bv [6] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
    logic [31:0] ex [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFD, 32'd1};
    int lat;
    for (int i = 0; i < 6; i++) begin
      start_op(f[i], av[i], bv[i]);
      wait_done(0, lat);
      tests_run++;
      if (result !== ex[i] || lat !== 33) begin
        tests_failed++;
        $display("FAIL div_vec%0d f3=%0d: result=%h lat=%0d, want %h lat=33", i, f[i], result, lat, ex[i]);
      end
      tick();
    end
  endtask

  task automatic test_boundaries();
    logic [2:0]  f  [7] = '{3'd5, 3'd6, 3'd4, 3'd6, 3'd4, 3'd6, 3'd7};
    logic [31:0] av [7] = '{32'h1234, 32'h1234, 32'h8000_0000, 32'h8000_0000,
                            32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
    logic [31:0] bv [7] = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0};
    logic [31:0] ex [7] = '{32'hFFFF_FFFF, 32'h1234, 32'h8000_0000, 32'h0,
                            32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
    int lat;
    for (int i = 0; i < 7; i++) begin
      start_op(f[i], av[i], bv[i]);
      wait_done(0, lat);
      tests_run++;
      if (result !== ex[i] || lat !== 33) begin
        tests_failed++;
        $display("FAIL bound_vec%0d f3=%0d: result=%h lat=%0d, want %h lat=33", i, f[i], result, lat, ex[i]);
      end
      tick();
    end
  endtask

  task automatic test_start_while_busy();
    int lat;
    start_op(3'd5, 32'd100, 32'd7);
    repeat (9) tick();
    funct3 = 3'd0;
    a      = 32'd5;
    b      = 32'd5;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL busy_start_busy: busy=%b want 1", busy);
    end
    wait_done(10, lat);
    tests_run++;
    if (result !== 32'd14 || lat !== 33) begin
      tests_failed++;
      $display("FAIL busy_start_ignored: result=%h lat=%0d, want 0000000e lat=33", result, lat);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat;
    start_op(3'd0, 32'd3, 32'd5);
    wait_done(0, lat);
    tests_run++;
    if (result !== 32'd15 || lat !== 33) begin
      tests_failed++;
      $display("FAIL b2b_first: result=%h lat=%0d, want 0000000f lat=33", result, lat);
    end
    // Still in the done cycle: this start must be accepted.
    start_op(3'd3, 32'h0001_0000, 32'h0001_0000);
    tests_run++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_accept: busy=%b done=%b, want 1/0", busy, done);
    end
    wait_done(0, lat);
    tests_run++;
    if (result !== 32'd1 || lat !== 33) begin
      tests_failed++;
      $display("FAIL b2b_second: result=%h lat=%0d, want 00000001 lat=33", result, lat);
    end
    tick();
  endtask

  task automatic test_flush();
    int dones;
    start_op(3'd0, 32'd9, 32'd9);
    repeat (4) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd1) begin
      tests_failed++;
      $display("FAIL flush_abort: busy=%b done=%b result=%h, want 0/0/00000001", busy, done, result);
    end
    dones = 0;
    repeat (40) begin
      tick();
      if (done === 1'b1) dones++;
    end
    tests_run++;
    if (dones !== 0 || result !== 32'd1) begin
      tests_failed++;
      $display("FAIL flush_no_done: dones=%0d result=%h, want 0/00000001", dones, result);
    end
    funct3 = 3'd0;
    a      = 32'd3;
    b      = 32'd3;
    start  = 1'b1;
    flush  = 1'b1;
    tick();
    start  = 1'b0;
    flush  = 1'b0;
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_over_start: busy=%b want 0", busy);
    end
    dones = 0;
    repeat (40) begin
      tick();
      if (done === 1'b1) dones++;
    end
    tests_run++;
    if (dones !== 0 || result !== 32'd1) begin
      tests_failed++;
      $display("FAIL flush_start_dropped: dones=%0d result=%h, want 0/00000001", dones, result);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat;
    start_op(3'd4, 32'd100, 32'd7);
    repeat (19) tick();
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_mid_op: busy=%b done=%b result=%h, want 0/0/00000000", busy, done, result);
    end
    #2;
    reset_n = 1'b1;
    tick();
    start_op(3'd7, 32'd100, 32'd7);
    wait_done(0, lat);
    tests_run++;
    if (result !== 32'd2 || lat !== 33) begin
      tests_failed++;
      $display("FAIL after_reset_op: result=%h lat=%0d, want 00000002 lat=33", result, lat);
    end
    tick();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_mul_timing();
    test_multiply();
    test_divide();
    test_boundaries();
    test_start_while_busy();
    test_back_to_back();
    test_flush();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
